// File: rtl/mult_16_16_top_if.sv
// Operand/result bundle for mult_16_16_top.
// master: operand source / result sink; slave: the multiplier.
interface mult_16_16_top_if;
  logic        IN_VLD;
  logic [15:0] A_NUM;
  logic [15:0] B_NUM;
  logic [31:0] C_NUM;
  logic        OUT_VLD;

  modport master (
    output IN_VLD,
    output A_NUM,
    output B_NUM,
    input  C_NUM,
    input  OUT_VLD
  );

  modport slave (
    input  IN_VLD,
    input  A_NUM,
    input  B_NUM,
    output C_NUM,
    output OUT_VLD
  );
endinterface

// File: rtl/mult_16_16_top.sv
// 16x16 -> 32 signed multiplier: radix-4 Booth recoding of A_NUM, Wallace
// tree of 3:2 carry-save adders, one 32-bit carry-propagate adder, and a
// registered output. Full throughput, no backpressure.
// Build option: define MULT_PIPE_EN to register the tree's sum/carry rows
// (plus valid) ahead of the final adder; latency goes from 1 to 2 cycles
// and results are bit-identical in both builds.
module mult_16_16_top (
  input  logic            sys_clk,
  input  logic            sys_rst,
  mult_16_16_top_if.slave mult_if
);

  // 3:2 compressor over 32-bit rows; returns {carry<<1, sum}. Bits carried
  // past bit 31 are dropped, which is harmless modulo 2^32.
  function automatic logic [63:0] csa(input logic [31:0] x,
                                      input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  // A_NUM with the implicit A[-1]=0 appended at the bottom.
  logic [16:0] w_a_ext;
  // B_NUM sign-extended to full product width.
  logic [31:0] w_b_ext;
  logic [31:0] w_pp [8];
  // One +1 per negated digit, at bit 2i; the positions never collide.
  logic [31:0] w_corr;

  assign w_a_ext = {mult_if.A_NUM, 1'b0};
  assign w_b_ext = {{16{mult_if.B_NUM[15]}}, mult_if.B_NUM};

  // Booth recoding: digit i from (A[2i+1], A[2i], A[2i-1]); negative digits
  // are formed as one's complement plus a correction bit at weight 2^(2i).
  always_comb begin
    logic [2:0]  trip;
    logic [31:0] mag;
    logic        neg;
    w_corr = '0;
    trip   = '0;
    mag    = '0;
    neg    = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      trip = w_a_ext[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: begin mag = w_b_ext;      neg = 1'b0; end
        3'b011:         begin mag = w_b_ext << 1; neg = 1'b0; end
        3'b100:         begin mag = w_b_ext << 1; neg = 1'b1; end
        3'b101, 3'b110: begin mag = w_b_ext;      neg = 1'b1; end
        default:        begin mag = '0;           neg = 1'b0; end
      endcase
      w_pp[i] = (neg ? ~mag : mag) << (2*i);
      if (neg) w_corr[2*i] = 1'b1;
    end
  end

  logic [31:0] w_sum;
  logic [31:0] w_carry;

  // Wallace reduction of 9 rows (8 partial products + correction row):
  // 9 -> 6 -> 4 -> 3 -> 2.
  always_comb begin
    logic [31:0] s1a, c1a, s1b, c1b, s1c, c1c;
    logic [31:0] s2a, c2a, s2b, c2b;
    logic [31:0] s3, c3;
    {c1a, s1a} = csa(w_pp[0], w_pp[1], w_pp[2]);
    {c1b, s1b} = csa(w_pp[3], w_pp[4], w_pp[5]);
    {c1c, s1c} = csa(w_pp[6], w_pp[7], w_corr);
    {c2a, s2a} = csa(s1a, c1a, s1b);
    {c2b, s2b} = csa(c1b, s1c, c1c);
    {c3,  s3 } = csa(s2a, c2a, s2b);
    {w_carry, w_sum} = csa(s3, c3, c2b);
  end

  logic [31:0] w_fin_sum;
  logic [31:0] w_fin_carry;
  logic        w_fin_vld;

`ifdef MULT_PIPE_EN
  logic [31:0] r_sum;
  logic [31:0] r_carry;
  logic        r_vld_p;

  // Register the two carry-save rows and their valid ahead of the final adder.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_vld_p <= 1'b0;
    end else begin
      r_vld_p <= mult_if.IN_VLD;
      if (mult_if.IN_VLD) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign w_fin_sum   = r_sum;
  assign w_fin_carry = r_carry;
  assign w_fin_vld   = r_vld_p;
`else
  assign w_fin_sum   = w_sum;
  assign w_fin_carry = w_carry;
  assign w_fin_vld   = mult_if.IN_VLD;
`endif

  logic [31:0] r_c_num;
  logic        r_out_vld;

  // Final carry-propagate add into the output register; the product holds
  // when no new operands arrive, and reset squashes anything in flight.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_c_num   <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= w_fin_vld;
      if (w_fin_vld) r_c_num <= w_fin_sum + w_fin_carry;
    end
  end

  assign mult_if.C_NUM   = r_c_num;
  assign mult_if.OUT_VLD = r_out_vld;

endmodule

// File: tb/tb_mult_16_16_top.sv
// Self-checking bench for mult_16_16_top. A scoreboard queue holds each
// accepted operand pair's expected product and the cycle it is due; every
// cycle OUT_VLD and C_NUM are compared against it.
module tb_mult_16_16_top;

`ifdef MULT_PIPE_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic sys_clk;
  logic sys_rst;

  mult_16_16_top_if mult_if ();

  mult_16_16_top dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .mult_if (mult_if)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned due;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_c;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  // use_exp selects a fixed expected product instead of the arithmetic model.
  task automatic step(input bit rst, input bit vld, input logic [15:0] a,
                      input logic [15:0] b, input bit use_exp,
                      input logic [31:0] exp_val, input string tag);
    exp_t        e;
    logic [31:0] exp_c;
    logic [31:0] exp_v;
    sys_rst        = rst;
    mult_if.IN_VLD = vld;
    mult_if.A_NUM  = a;
    mult_if.B_NUM  = b;
    @(posedge sys_clk);
    cyc++;
    if (rst) begin
      sb_q.delete();
      last_c = '0;
    end else if (vld) begin
      e.due = cyc + LAT - 1;
      e.val = use_exp ? exp_val
                      : 32'(int'($signed(a)) * int'($signed(b)));
      sb_q.push_back(e);
    end
    @(negedge sys_clk);
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      exp_v  = 32'd1;
      exp_c  = sb_q[0].val;
      last_c = exp_c;
      void'(sb_q.pop_front());
    end else begin
      exp_v = 32'd0;
      exp_c = last_c;
    end
    chk({tag, ".out_vld"}, {31'b0, mult_if.OUT_VLD}, exp_v);
    chk({tag, ".c_num"}, mult_if.C_NUM, exp_c);
  endtask

  task automatic idle(input int unsigned n, input string tag);
    for (int unsigned k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    bit          rv;
    bit          rr;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    last_c   = '0;
    sys_rst        = 1'b1;
    mult_if.IN_VLD = 1'b1;
    mult_if.A_NUM  = 16'h1234;
    mult_if.B_NUM  = 16'h5678;

    // Reset held two cycles with live operands: they must be discarded.
    step(1, 1, 16'h1234, 16'h5678, 0, '0, "reset");
    step(1, 1, 16'h1234, 16'h5678, 0, '0, "reset");
    idle(2, "post_reset");

    // Directed vectors with fixed expected products.
    step(0, 1, 16'h3524, 16'h5E81, 1, 32'h139DFF24, "basic");
    step(0, 1, 16'hFFFF, 16'h0002, 1, 32'hFFFFFFFE, "neg1x2");
    step(0, 1, 16'hFFFF, 16'hFFFF, 1, 32'h00000001, "neg1xneg1");
    step(0, 1, 16'h8000, 16'h8000, 1, 32'h40000000, "minxmin");
    step(0, 1, 16'h7FFF, 16'h8000, 1, 32'hC0008000, "maxxmin");
    step(0, 1, 16'h8000, 16'h7FFF, 1, 32'hC0008000, "minxmax");
    step(0, 1, 16'h0000, 16'h8000, 1, 32'h00000000, "zero");
    idle(LAT + 1, "flush1");

    // 101 back-to-back random pairs.
    for (int unsigned k = 0; k < 101; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(0, 1, ra, rb, 0, '0, "stream");
    end
    idle(LAT + 1, "flush2");

    // Reset one cycle after three valid inputs; nothing may leak out.
    for (int unsigned k = 0; k < 3; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(0, 1, ra, rb, 0, '0, "pre_rst");
    end
    step(1, 1, 16'h1111, 16'h2222, 0, '0, "mid_rst");
    step(0, 1, 16'h0003, 16'hFFFD, 1, 32'hFFFFFFF7, "after_rst");
    idle(LAT + 2, "flush3");

    // Gap in IN_VLD: product held through the gap.
    step(0, 1, 16'd2, 16'd3, 1, 32'd6, "gap_a");
    step(0, 0, 16'd9, 16'd9, 0, '0, "gap_idle");
    step(0, 1, 16'd4, 16'd5, 1, 32'd20, "gap_b");
    idle(LAT + 2, "flush4");

    // Random valid pattern with occasional resets.
    for (int unsigned k = 0; k < 200; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 39) == 0);
      step(rr, rv, ra, rb, 0, '0, "mixed");
    end
    idle(LAT + 2, "flush5");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_16_16_top.md
MULT_16_16_TOP -- requirements
Module: mult_16_16_top

Interface
REQ-001 Parameters: none; operand widths fixed at 16 x 16 -> 32.
REQ-002 sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 IN_VLD  input  1  operands on A_NUM/B_NUM valid this cycle.
REQ-005 A_NUM  input  16  multiplier, two's-complement signed.
REQ-006 B_NUM  input  16  multiplicand, two's-complement signed.
REQ-007 C_NUM  output  32  product A_NUM*B_NUM, two's-complement signed, registered.
REQ-008 OUT_VLD  output  1  C_NUM holds a new product this cycle, registered.

Function
REQ-009 The block SHALL compute the exact full-width signed product C_NUM = A_NUM * B_NUM; no truncation, rounding or saturation.
REQ-010 Partial products SHALL come from radix-4 Booth recoding of A_NUM: 8 digits in {-2,-1,0,+1,+2}, each from bit triplet (A[2i+1], A[2i], A[2i-1]), with A[-1]=0.
REQ-011 Each partial product SHALL be sign-extended or sign-encoded to 32 bits, and SHALL be shifted left by 2i; negation SHALL use one's complement plus a +1 correction bit.
REQ-012 The 8 partial products plus correction bits SHALL be reduced to two rows by a Wallace tree of 3:2 carry-save adders, then summed by one 32-bit carry-propagate adder; carry-out beyond bit 31 SHALL be discarded.
REQ-013 Latency SHALL be 1 cycle without MULT_PIPE_EN: operands sampled at edge N with IN_VLD=1 appear on C_NUM with OUT_VLD=1 after edge N.
REQ-014 A new operand pair SHALL be accepted every cycle (full throughput); there is no backpressure.
REQ-015 When IN_VLD=0, OUT_VLD SHALL deassert one latency later, and C_NUM SHALL hold its last value.
REQ-016 Corner operands SHALL be exact: -32768*-32768=0x40000000, and 0x7FFF*0x8000=0xC0008000.

Reset
REQ-017 While sys_rst=1 at a rising edge, C_NUM SHALL become 0x00000000 and OUT_VLD SHALL become 0; all pipeline registers SHALL clear, with their valid bits at 0.
REQ-018 Reset SHALL take priority over IN_VLD in the same cycle; operands presented during reset SHALL be discarded.
REQ-019 Reset asserted mid-pipeline SHALL squash in-flight products: no OUT_VLD pulse SHALL appear for operands accepted before the reset edge.
REQ-020 The first valid operand after reset release SHALL produce a correct result with the normal latency.

Configuration
REQ-021 Macro MULT_PIPE_EN: when defined, a register stage SHALL sit between the Wallace tree output (sum and carry rows, plus valid) and the final adder; latency becomes 2 cycles; throughput stays 1 per cycle.
REQ-022 Without MULT_PIPE_EN, the tree and final adder SHALL be combinational between the input and the output register; latency is 1 cycle.
REQ-023 Results SHALL be bit-identical in both configurations; only latency differs.

Verification
REQ-024 Reset: hold sys_rst=1 for 2 cycles with IN_VLD=1, A=0x1234, B=0x5678 -> C_NUM=0x00000000, OUT_VLD=0.
REQ-025 Basic case: A=0x3524, B=0x5E81 -> C_NUM=0x139DFF24 with OUT_VLD=1 after 1 cycle (2 cycles with MULT_PIPE_EN).
REQ-026 Signs: A=0xFFFF, B=0x0002 -> 0xFFFFFFFE; A=0xFFFF, B=0xFFFF -> 0x00000001; A=0x8000, B=0x8000 -> 0x40000000; A=0x7FFF, B=0x8000 -> 0xC0008000.
REQ-027 Throughput: 101 back-to-back random pairs with IN_VLD=1 -> every C_NUM matches a signed reference model in order, with OUT_VLD continuously high.
REQ-028 Reset mid-stream: assert sys_rst one cycle after 3 valid inputs -> no stale OUT_VLD after reset; the next input A=0x0003, B=0xFFFD yields 0xFFFFFFF7.
REQ-029 Gaps: IN_VLD toggling 1,0,1 with A=2,B=3 then A=4,B=5 -> OUT_VLD pattern 1,0,1, C_NUM=6 held through the gap, then 20.
